button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/reaction_pkg.sv | 6 +
 rtl/debounce_channel.sv | 34 +++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared timing constants for the reaction-game front end
package reaction_pkg;
  localparam int CLK_HZ = 50000000;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES = 100000000;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchronize, debounce and rise-detect one raw button
module debounce_channel
  import reaction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic lvl_d;
  // two-flop synchronizer feeding a restart-on-reversion counter; the level flips once the difference has persisted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      lvl_d <= lvl;
      if (sync[1] == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else cnt <= cnt + 1'b1;
    end
  assign rise = lvl & ~lvl_d;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced press pulses plus a long-hold reset request
module button_conditioner
  import reaction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start_raw,
  input  logic react_raw,
  input  logic reset_raw,
  output logic start_btn,
  output logic react_btn,
  output logic reset_req,
  output logic start_lvl,
  output logic react_lvl,
  output logic reset_lvl
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  logic [1:0] rst_sync;
  logic rst_n;
  logic reset_rise;
  logic [HW-1:0] hold;
  // reset asserts immediately and releases two edges later, aligned to clk
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .rst_n(rst_n), .raw(start_raw), .lvl(start_lvl), .rise(start_btn)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_react (
    .clk(clk), .rst_n(rst_n), .raw(react_raw), .lvl(react_lvl), .rise(react_btn)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
    .clk(clk), .rst_n(rst_n), .raw(reset_raw), .lvl(reset_lvl), .rise(reset_rise)
  );
  // hold timer starts on the debounced press, saturates, and clears once released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold <= '0;
    else hold <= !reset_lvl ? '0 : reset_rise ? HW'(1) : hold == HW'(HOLD_CYCLES) ? hold : hold + 1'b1;
  assign reset_req = reset_lvl && hold == HW'(HOLD_CYCLES);
endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_raw = 1'b0, react_raw = 1'b0, reset_raw = 1'b0;
  logic start_btn, react_btn, reset_req, start_lvl, react_lvl, reset_lvl;
  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start_raw(start_raw), .react_raw(react_raw), .reset_raw(reset_raw),
    .start_btn(start_btn), .react_btn(react_btn), .reset_req(reset_req),
    .start_lvl(start_lvl), .react_lvl(react_lvl), .reset_lvl(reset_lvl)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({start_btn, react_btn, reset_req, start_lvl, react_lvl, reset_lvl} !== 6'b0) begin
      n_err++;
      $display("FAIL %s outputs got %b exp 000000", tag,
               {start_btn, react_btn, reset_req, start_lvl, react_lvl, reset_lvl});
    end
  endtask

  task automatic test_reset;
    repeat (3) step();
    check_all_zero("reset_held");
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_all_zero("reset_exit");
    end
  endtask

  task automatic test_clean_press;
    start_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if (start_lvl !== (k >= 6)) begin n_err++; $display("FAIL clean_lvl k=%0d got %b exp %b", k, start_lvl, k >= 6); end
      n_cmp++;
      if (start_btn !== (k == 6)) begin n_err++; $display("FAIL clean_btn k=%0d got %b exp %b", k, start_btn, k == 6); end
      n_cmp++;
      if (react_btn !== 1'b0) begin n_err++; $display("FAIL clean_react k=%0d got %b exp 0", k, react_btn); end
    end
    start_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (start_lvl !== (k < 6)) begin n_err++; $display("FAIL release_lvl k=%0d got %b exp %b", k, start_lvl, k < 6); end
      n_cmp++;
      if (start_btn !== 1'b0) begin n_err++; $display("FAIL release_btn k=%0d got %b exp 0", k, start_btn); end
    end
  endtask

  task automatic test_glitch;
    start_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) start_raw = 1'b0;
      step();
      n_cmp++;
      if (start_lvl !== 1'b0 || start_btn !== 1'b0) begin
        n_err++; $display("FAIL glitch3 k=%0d got lvl=%b btn=%b exp 0 0", k, start_lvl, start_btn);
      end
    end
    start_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 4) start_raw = 1'b0;
      n_cmp++;
      if (start_lvl !== (k >= 6 && k < 10)) begin
        n_err++; $display("FAIL glitch4_lvl k=%0d got %b exp %b", k, start_lvl, k >= 6 && k < 10);
      end
      n_cmp++;
      if (start_btn !== (k == 6)) begin n_err++; $display("FAIL glitch4_btn k=%0d got %b exp %b", k, start_btn, k == 6); end
    end
  endtask

  task automatic test_bounce;
    for (int p = 0; p < 4; p++) begin
      react_raw = (p % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        step();
        n_cmp++;
        if (react_lvl !== 1'b0 || react_btn !== 1'b0) begin
          n_err++; $display("FAIL bounce_phase p=%0d got lvl=%b btn=%b exp 0 0", p, react_lvl, react_btn);
        end
      end
    end
    react_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (react_btn !== (k == 6)) begin n_err++; $display("FAIL bounce_btn k=%0d got %b exp %b", k, react_btn, k == 6); end
      n_cmp++;
      if (react_lvl !== (k >= 6)) begin n_err++; $display("FAIL bounce_lvl k=%0d got %b exp %b", k, react_lvl, k >= 6); end
    end
    react_raw = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_simultaneous;
    start_raw = 1'b1;
    react_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++;
      if ({start_btn, react_btn} !== {2{k == 6}}) begin
        n_err++; $display("FAIL simul_btn k=%0d got %b%b exp %b%b", k, start_btn, react_btn, k == 6, k == 6);
      end
    end
    start_raw = 1'b0;
    react_raw = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_hold;
    reset_raw = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_cmp++;
      if (reset_lvl !== (k >= 6)) begin n_err++; $display("FAIL hold_lvl k=%0d got %b exp %b", k, reset_lvl, k >= 6); end
      n_cmp++;
      if (reset_req !== (k >= 14)) begin n_err++; $display("FAIL hold_req k=%0d got %b exp %b", k, reset_req, k >= 14); end
    end
    reset_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (reset_lvl !== (k < 6)) begin n_err++; $display("FAIL unhold_lvl k=%0d got %b exp %b", k, reset_lvl, k < 6); end
      n_cmp++;
      if (reset_req !== (k < 6)) begin n_err++; $display("FAIL unhold_req k=%0d got %b exp %b", k, reset_req, k < 6); end
    end
  endtask

  task automatic test_reset_mid;
    start_raw = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check_all_zero("mid_assert");
    for (int k = 1; k <= 3; k++) begin
      step();
      check_all_zero("mid_held");
    end
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_cmp++;
      if (start_btn !== (k == 8)) begin n_err++; $display("FAIL mid_btn k=%0d got %b exp %b", k, start_btn, k == 8); end
      n_cmp++;
      if (start_lvl !== (k >= 8)) begin n_err++; $display("FAIL mid_lvl k=%0d got %b exp %b", k, start_lvl, k >= 8); end
    end
    reset_raw = 1'b1;
    repeat (14) step();
    n_cmp++;
    if (reset_req !== 1'b1) begin n_err++; $display("FAIL req_before_reset got %b exp 1", reset_req); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (reset_req !== 1'b0) begin n_err++; $display("FAIL req_async_drop got %b exp 0", reset_req); end
    check_all_zero("req_reset");
    start_raw = 1'b0;
    reset_raw = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_all_zero("final_exit");
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
